// File: rtl/am_ccreg_pkg.sv
// Shared definitions for the condition-code register: order codes, bit positions, merge helper.
package am_ccreg_pkg;

    localparam int unsigned CC_W  = 8;
    localparam int unsigned CC_FW = 4;
    localparam int unsigned CC_OW = 3;

    // Micro-order codes
    localparam logic [CC_OW-1:0] CC_HOLD = 3'd0;
    localparam logic [CC_OW-1:0] CC_LDF  = 3'd1;
    localparam logic [CC_OW-1:0] CC_LDT  = 3'd2;
    localparam logic [CC_OW-1:0] CC_LDE  = 3'd3;
    localparam logic [CC_OW-1:0] CC_LDA  = 3'd4;
    localparam logic [CC_OW-1:0] CC_SETB = 3'd5;
    localparam logic [CC_OW-1:0] CC_CLRB = 3'd6;
    localparam logic [CC_OW-1:0] CC_CLR  = 3'd7;

    // Bit positions within q
    localparam int unsigned CC_C  = 0;
    localparam int unsigned CC_Z  = 1;
    localparam int unsigned CC_N  = 2;
    localparam int unsigned CC_V  = 3;
    localparam int unsigned CC_T0 = 4;

    localparam logic [CC_W-1:0] CC_LO_SEL  = 8'h0F;
    localparam logic [CC_W-1:0] CC_HI_SEL  = 8'hF0;
    localparam logic [CC_W-1:0] CC_ALL_SEL = 8'hFF;

    // Bits in sel are reloaded from src; sticky bits OR with their old value, others keep q.
    function automatic logic [CC_W-1:0] cc_merge(
        input logic [CC_W-1:0] cur,
        input logic [CC_W-1:0] src,
        input logic [CC_W-1:0] sticky,
        input logic [CC_W-1:0] sel
    );
        return (cur & ~sel) | (sel & (src | (cur & sticky)));
    endfunction

endpackage

// File: rtl/am_ccsync.sv
// Two-stage synchronizer for the asynchronous test lines.
module am_ccsync
    import am_ccreg_pkg::*;
(
    input  logic             cp,
    input  logic             mr_,
    input  logic [CC_FW-1:0] d,
    output logic [CC_FW-1:0] q
);

    logic [CC_FW-1:0] s1;

    always_ff @(posedge cp or negedge mr_) begin
        if (!mr_) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/am_ccreg.sv
// Condition-code register feeding the sequencer condition mux.
// Build option CCREG_SYNC_EN: route t through the am_ccsync 2-flop synchronizer.
module am_ccreg
    import am_ccreg_pkg::*;
#(
    parameter logic [CC_W-1:0] STICKY_MASK = 8'b0000_1000
) (
    input  logic             cp,
    input  logic             mr_,
    input  logic             ce_,
    input  logic [CC_OW-1:0] i,
    input  logic [CC_FW-1:0] f,
    input  logic [CC_FW-1:0] t,
    input  logic [CC_OW-1:0] bsel,
    output logic [CC_W-1:0]  q,
    output logic             nz
);

    logic [CC_FW-1:0] ts;
    logic [CC_FW-1:0] tp;
    logic [CC_FW-1:0] rise;
    logic [CC_W-1:0]  bmask;
    logic             bsel_ok;
    logic [CC_W-1:0]  q_next;

`ifdef CCREG_SYNC_EN
    am_ccsync u_sync (
        .cp  (cp),
        .mr_ (mr_),
        .d   (t),
        .q   (ts)
    );
`else
    assign ts = t;
`endif

    // Edge history runs every cycle, so rises outside LDE are consumed and lost.
    always_ff @(posedge cp or negedge mr_) begin
        if (!mr_) begin
            tp <= '0;
        end else begin
            tp <= ts;
        end
    end

    assign rise = ts & ~tp;

    // One-hot bit select; an unknown index is flagged rather than silently defaulted.
    always_comb begin
        bmask   = '0;
        bsel_ok = 1'b1;
        case (bsel)
            3'd0:    bmask = 8'h01;
            3'd1:    bmask = 8'h02;
            3'd2:    bmask = 8'h04;
            3'd3:    bmask = 8'h08;
            3'd4:    bmask = 8'h10;
            3'd5:    bmask = 8'h20;
            3'd6:    bmask = 8'h40;
            3'd7:    bmask = 8'h80;
            default: bsel_ok = 1'b0;
        endcase
    end

    // Order decode
    always_comb begin
        q_next = q;
        if (!ce_) begin
            case (i)
                CC_HOLD: q_next = q;
                CC_LDF:  q_next = cc_merge(q, {4'h0, f}, STICKY_MASK, CC_LO_SEL);
                CC_LDT:  q_next = cc_merge(q, {ts, 4'h0}, STICKY_MASK, CC_HI_SEL);
                CC_LDE:  q_next = q | (CC_W'(rise) << CC_T0);
                CC_LDA:  q_next = cc_merge(q, {ts, f}, STICKY_MASK, CC_ALL_SEL);
                CC_SETB: q_next = bsel_ok ? (q | bmask) : 'x;
                CC_CLRB: q_next = bsel_ok ? (q & ~bmask) : 'x;
                CC_CLR:  q_next = '0;
                default: q_next = 'x;
            endcase
        end
    end

    always_ff @(posedge cp or negedge mr_) begin
        if (!mr_) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    assign nz = |q;

endmodule
